// File: rtl/ad7606_emulator.sv
// Device-side model of an AD7606 in parallel mode: CONVST starts a BUSY window, then RD falling edges shift out channel words.
// Optional ADC_NOISE_EN: XORs a 2-bit LFSR dither onto each latched channel word.
`timescale 1ns/1ps
module ad7606_emulator #(
  parameter int CONV_CYCLES = 200,
  parameter int CH_NUM      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        conv,
  input  logic        rd,
  output logic        busy,
  output logic [15:0] data_out,
  output logic        frstdata
);

  typedef enum logic [1:0] {IDLE, CONV, READ} state_t;

  localparam logic [15:0] CONV_LAST = 16'(CONV_CYCLES - 1);
  localparam logic [2:0]  IDX_LAST  = 3'(CH_NUM - 1);

  state_t      state_reg, state_next;
  logic [15:0] busy_cnt_reg, busy_cnt_next;
  logic [2:0]  idx_reg, idx_next;
  logic [12:0] sample_cnt_reg;
  logic        conv_d_reg, rd_d_reg;
  logic        busy_reg, frstdata_reg;
  logic [15:0] data_out_reg;
  logic [15:0] ch_reg  [0:7];
  logic [15:0] ch_word [0:7];
  logic [15:0] noise_mask;
  logic        conv_rise, rd_fall, latch_en, load_en;

  assign conv_rise = conv & ~conv_d_reg;
  assign rd_fall   = ~rd & rd_d_reg;

`ifdef ADC_NOISE_EN
  logic [15:0] lfsr_reg;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11; steps once per conversion at the latch cycle.
  assign lfsr_fb    = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign noise_mask = {14'd0, lfsr_reg[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= 16'hACE1;
    end else if (latch_en) begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
    end
  end
`else
  assign noise_mask = 16'h0000;
`endif

  // Channel word pattern: sample number in the upper bits, channel number in the low three.
  for (genvar gi = 0; gi < 8; gi++) begin : g_word
    assign ch_word[gi] = {sample_cnt_reg, 3'(gi)} ^ noise_mask;
  end

  always_comb begin
    state_next    = state_reg;
    busy_cnt_next = busy_cnt_reg;
    idx_next      = idx_reg;
    latch_en      = 1'b0;
    load_en       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (conv_rise) begin
          state_next    = CONV;
          busy_cnt_next = 16'd0;
        end
      end
      CONV: begin
        if (busy_cnt_reg == CONV_LAST) begin
          state_next    = READ;
          busy_cnt_next = 16'd0;
          idx_next      = 3'd0;
          latch_en      = 1'b1;
        end else begin
          busy_cnt_next = busy_cnt_reg + 16'd1;
        end
      end
      READ: begin
        // A new conversion request aborts the readout and suppresses a coincident read.
        if (conv_rise) begin
          state_next    = CONV;
          busy_cnt_next = 16'd0;
          idx_next      = 3'd0;
        end else if (rd_fall) begin
          load_en = 1'b1;
          if (idx_reg == IDX_LAST) begin
            state_next = IDLE;
            idx_next   = 3'd0;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      busy_cnt_reg <= 16'd0;
      idx_reg      <= 3'd0;
      conv_d_reg   <= 1'b0;
      rd_d_reg     <= 1'b1;
    end else begin
      state_reg    <= state_next;
      busy_cnt_reg <= busy_cnt_next;
      idx_reg      <= idx_next;
      conv_d_reg   <= conv;
      rd_d_reg     <= rd;
    end
  end

  // busy trails the state register by one cycle so it spans exactly CONV_CYCLES clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= 1'b0;
    end else begin
      busy_reg <= (state_reg == CONV);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_reg <= 13'd0;
      for (int i = 0; i < 8; i++) begin
        ch_reg[i] <= 16'h0000;
      end
    end else if (latch_en) begin
      sample_cnt_reg <= sample_cnt_reg + 13'd1;
      for (int i = 0; i < 8; i++) begin
        ch_reg[i] <= ch_word[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_reg <= 16'h0000;
      frstdata_reg <= 1'b0;
    end else if (load_en) begin
      data_out_reg <= ch_reg[idx_reg];
      frstdata_reg <= (idx_reg == 3'd0);
    end
  end

  assign busy     = busy_reg;
  assign data_out = data_out_reg;
  assign frstdata = frstdata_reg;

endmodule

// File: tb/tb_ad7606_emulator.sv
// Directed bench for ad7606_emulator (CONV_CYCLES=10, CH_NUM=8); expected words come from a small sample/LFSR model.
`timescale 1ns/1ps
module tb_ad7606_emulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        conv = 1'b0;
  logic        rd = 1'b1;
  logic        busy;
  logic [15:0] data_out;
  logic        frstdata;

  int pass_cnt = 0;
  int check_cnt = 0;

  logic [12:0] m_cnt = 13'd0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [15:0] exp_word [0:7];

  ad7606_emulator #(.CONV_CYCLES(10), .CH_NUM(8)) dut (
    .clk(clk), .rst_n(rst_n), .conv(conv), .rd(rd),
    .busy(busy), .data_out(data_out), .frstdata(frstdata)
  );

  always #10 clk = ~clk;

  // Model of one latch: words from the current sample count (plus dither), then advance.
  task automatic model_latch();
    logic [15:0] mask;
`ifdef ADC_NOISE_EN
    mask = {14'd0, m_lfsr[1:0]};
`else
    mask = 16'h0000;
`endif
    for (int n = 0; n < 8; n++) exp_word[n] = {m_cnt, 3'(n)} ^ mask;
    m_cnt  = m_cnt + 13'd1;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  task automatic model_reset();
    m_cnt  = 13'd0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic read_word(output logic [15:0] d, output logic f);
    @(posedge clk); #1; rd = 1'b0;
    @(posedge clk); #1; rd = 1'b1;
    @(posedge clk); #1;
    d = data_out;
    f = frstdata;
    $display("read data=%h frst=%b", d, f);
  endtask

  // Conversion started at a posedge; returns busy-profile errors, data_out after the start edge and at the end.
  task automatic run_conv(input bit mid_conv, input bit rd_busy, input bit rd_at_start,
                          output int busy_err, output logic [15:0] start_val, output logic [15:0] end_val);
    logic exp_busy;
    busy_err = 0;
    @(posedge clk); #1;
    conv = 1'b1;
    if (rd_at_start) rd = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      exp_busy = (k >= 2 && k <= 11) ? 1'b1 : 1'b0;
      if (busy !== exp_busy) busy_err++;
      if (k == 1) begin
        conv = 1'b0;
        rd = 1'b1;
        start_val = data_out;
      end
      if (mid_conv && k == 5) conv = 1'b1;
      if (mid_conv && k == 6) conv = 1'b0;
      if (rd_busy && k == 3) rd = 1'b0;
      if (rd_busy && k == 4) rd = 1'b1;
    end
    end_val = data_out;
    model_latch();
    $display("conversion done busy_err=%0d", busy_err);
  endtask

  task automatic test_reset();
    #5;
    check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else pass_cnt++;
    check_cnt++; if (data_out !== 16'h0000) $display("FAIL reset_data got=%h want=0000", data_out); else pass_cnt++;
    check_cnt++; if (frstdata !== 1'b0) $display("FAIL reset_frst got=%b want=0", frstdata); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_cnt++; if (busy !== 1'b0) $display("FAIL post_reset_busy got=%b want=0", busy); else pass_cnt++;
    check_cnt++; if (data_out !== 16'h0000) $display("FAIL post_reset_data got=%h want=0000", data_out); else pass_cnt++;
    check_cnt++; if (frstdata !== 1'b0) $display("FAIL post_reset_frst got=%b want=0", frstdata); else pass_cnt++;
  endtask

  task automatic read_all_check(input string tag);
    logic [15:0] d;
    logic f;
    for (int n = 0; n < 8; n++) begin
      read_word(d, f);
      check_cnt++; if (d !== exp_word[n]) $display("FAIL %s_data%0d got=%h want=%h", tag, n, d, exp_word[n]); else pass_cnt++;
      check_cnt++; if (f !== (n == 0)) $display("FAIL %s_frst%0d got=%b want=%b", tag, n, f, (n == 0)); else pass_cnt++;
    end
  endtask

  task automatic test_single();
    int be;
    logic [15:0] sv, ev, d;
    logic f;
    run_conv(1'b0, 1'b0, 1'b0, be, sv, ev);
    check_cnt++; if (be !== 0) $display("FAIL single_busy errors=%0d want=0", be); else pass_cnt++;
    read_all_check("single");
    // Readout complete: one more RD must not change the bus.
    read_word(d, f);
    check_cnt++; if (d !== exp_word[7]) $display("FAIL idle_rd_data got=%h want=%h", d, exp_word[7]); else pass_cnt++;
    check_cnt++; if (f !== 1'b0) $display("FAIL idle_rd_frst got=%b want=0", f); else pass_cnt++;
  endtask

  task automatic test_ignored_strobes();
    int be;
    logic [15:0] sv, ev, prev;
    prev = data_out;
    run_conv(1'b1, 1'b1, 1'b0, be, sv, ev);
    check_cnt++; if (be !== 0) $display("FAIL ignored_busy errors=%0d want=0", be); else pass_cnt++;
    check_cnt++; if (ev !== prev) $display("FAIL busy_rd_hold got=%h want=%h", ev, prev); else pass_cnt++;
    read_all_check("second");
  endtask

  task automatic test_reset_mid_read();
    int be;
    logic [15:0] sv, ev, d;
    logic f;
    run_conv(1'b0, 1'b0, 1'b0, be, sv, ev);
    check_cnt++; if (be !== 0) $display("FAIL rmr_busy errors=%0d want=0", be); else pass_cnt++;
    for (int n = 0; n < 4; n++) begin
      read_word(d, f);
      check_cnt++; if (d !== exp_word[n]) $display("FAIL rmr_data%0d got=%h want=%h", n, d, exp_word[n]); else pass_cnt++;
    end
    @(posedge clk); #1; rst_n = 1'b0;
    #2;
    check_cnt++; if (data_out !== 16'h0000) $display("FAIL async_data got=%h want=0000", data_out); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL async_busy got=%b want=0", busy); else pass_cnt++;
    check_cnt++; if (frstdata !== 1'b0) $display("FAIL async_frst got=%b want=0", frstdata); else pass_cnt++;
    @(posedge clk); #1; rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check_cnt++; if (data_out !== 16'h0000) $display("FAIL rel_data got=%h want=0000", data_out); else pass_cnt++;
    run_conv(1'b0, 1'b0, 1'b0, be, sv, ev);
    check_cnt++; if (be !== 0) $display("FAIL after_rst_busy errors=%0d want=0", be); else pass_cnt++;
    read_all_check("after_rst");
  endtask

  task automatic test_abort();
    int be;
    logic [15:0] sv, ev, d;
    logic f;
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    model_reset();
    run_conv(1'b0, 1'b0, 1'b0, be, sv, ev);
    for (int n = 0; n < 3; n++) begin
      read_word(d, f);
      check_cnt++; if (d !== exp_word[n]) $display("FAIL abort_pre%0d got=%h want=%h", n, d, exp_word[n]); else pass_cnt++;
    end
    // conv and RD fall together: conversion wins, bus keeps the third word.
    run_conv(1'b0, 1'b0, 1'b1, be, sv, ev);
    check_cnt++; if (sv !== exp_word_prev2(m_cnt)) $display("FAIL abort_tie got=%h want=%h", sv, exp_word_prev2(m_cnt)); else pass_cnt++;
    check_cnt++; if (be !== 0) $display("FAIL abort_busy errors=%0d want=0", be); else pass_cnt++;
    read_word(d, f);
    check_cnt++; if (d !== exp_word[0]) $display("FAIL abort_first got=%h want=%h", d, exp_word[0]); else pass_cnt++;
    check_cnt++; if (f !== 1'b1) $display("FAIL abort_frst got=%b want=1", f); else pass_cnt++;
    read_word(d, f);
    check_cnt++; if (d !== exp_word[1]) $display("FAIL abort_second got=%h want=%h", d, exp_word[1]); else pass_cnt++;
  endtask

  // Word 2 of the conversion before the current one (sample m_cnt-2), dither taken from the LFSR two steps back.
  function automatic logic [15:0] exp_word_prev2(input logic [12:0] cnt);
    logic [15:0] mask;
`ifdef ADC_NOISE_EN
    mask = {14'd0, 2'b01};
`else
    mask = 16'h0000;
`endif
    return {cnt - 13'd2, 3'd2} ^ mask;
  endfunction

  task automatic test_held_conv();
    int highs;
    logic [15:0] d;
    logic f;
    highs = 0;
    @(posedge clk); #1; conv = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) highs++;
    end
    model_latch();
    check_cnt++; if (highs !== 10) $display("FAIL held_busy_cycles got=%0d want=10", highs); else pass_cnt++;
    read_word(d, f);
    check_cnt++; if (d !== exp_word[0]) $display("FAIL held_first got=%h want=%h", d, exp_word[0]); else pass_cnt++;
    conv = 1'b0;
  endtask

  task automatic test_wrap();
    int be;
    logic [15:0] sv, ev, d;
    logic f;
    @(posedge clk); #1;
    force dut.sample_cnt_reg = 13'd8191;
    @(posedge clk); #1;
    release dut.sample_cnt_reg;
    m_cnt = 13'd8191;
    run_conv(1'b0, 1'b0, 1'b0, be, sv, ev);
    read_word(d, f);
    check_cnt++; if (d !== exp_word[0]) $display("FAIL wrap_last got=%h want=%h", d, exp_word[0]); else pass_cnt++;
    run_conv(1'b0, 1'b0, 1'b0, be, sv, ev);
    read_word(d, f);
    check_cnt++; if (d !== exp_word[0]) $display("FAIL wrap_zero got=%h want=%h", d, exp_word[0]); else pass_cnt++;
    check_cnt++; if (f !== 1'b1) $display("FAIL wrap_frst got=%b want=1", f); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_ignored_strobes();
    test_reset_mid_read();
    test_abort();
    test_held_conv();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
